// File: rtl/ship_placer_if.sv
// Ship placer bundle: player placement controls in, packed board and status out.
interface ship_placer_if #(
    parameter int N     = 5,
    parameter int LEN_W = 3
);
    localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1;

    logic              enable;
    logic [CW-1:0]     row;
    logic [CW-1:0]     col;
    logic [LEN_W-1:0]  ship_len;
    logic              vertical;
    logic [2:0]        target_ships;
    logic              place_btn;
    logic              clear_btn;
    logic [2*N*N-1:0]  board;
    logic [2:0]        ships_placed;
    logic              busy;
    logic              place_ok;
    logic              place_err;
    logic [1:0]        err_code;
    logic              finished;

    modport master (
        output enable, row, col, ship_len, vertical,
        output target_ships, place_btn, clear_btn,
        input  board, ships_placed, busy,
        input  place_ok, place_err, err_code, finished
    );

    modport slave (
        input  enable, row, col, ship_len, vertical,
        input  target_ships, place_btn, clear_btn,
        output board, ships_placed, busy,
        output place_ok, place_err, err_code, finished
    );
endinterface

// File: rtl/ship_placer.sv
// Battleship ship placement: bounds/quota gate, per-cell overlap scan,
// then per-cell write of an accepted ship into the N x N board.
module ship_placer #(
    parameter int N         = 5,
    parameter int MAX_SHIPS = 5,
    parameter int LEN_W     = 3
) (
    input  logic          clk,
    input  logic          rst,
    ship_placer_if.slave  bus
);
    localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam int SW = ((CW > LEN_W) ? CW : LEN_W) + 1;
    localparam int NC = N * N;
    localparam int IW = $clog2(NC);
    localparam int AW = 2 * SW + 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_BNDS  = 2'b01;
    localparam logic [1:0] E_OVLP  = 2'b10;
    localparam logic [1:0] E_QUOTA = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic [CW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             vert_q, vert_d;
    logic [NC-1:0]    cells_q, cells_d;
    logic [2:0]       ships_q, ships_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             pprev_q, cprev_q;

    logic             place_rel;
    logic             clear_rel;
    logic [SW-1:0]    start_ext;
    logic [SW-1:0]    cross_ext;
    logic [SW-1:0]    end_sum;
    logic             bounds_bad;
    logic             quota_hit;
    logic [SW-1:0]    rr;
    logic [SW-1:0]    cc;
    logic [IW-1:0]    idx;
    logic             last;

    assign place_rel = pprev_q & ~bus.place_btn;
    assign clear_rel = cprev_q & ~bus.clear_btn;

    assign start_ext = bus.vertical ? SW'(bus.row) : SW'(bus.col);
    assign cross_ext = bus.vertical ? SW'(bus.col) : SW'(bus.row);
    assign end_sum   = start_ext + SW'(bus.ship_len);

    // The fixed axis is also range-checked so a wide coordinate
    // can never address a cell outside the board.
    assign bounds_bad = (bus.ship_len == '0)
                      || (end_sum > SW'(N))
                      || (cross_ext >= SW'(N));

    assign quota_hit = (ships_q >= bus.target_ships)
                     || (int'(ships_q) >= MAX_SHIPS);

    assign rr   = SW'(row_q) + (vert_q ? SW'(k_q) : '0);
    assign cc   = SW'(col_q) + (vert_q ? '0 : SW'(k_q));
    assign idx  = IW'(AW'(rr) * AW'(N) + AW'(cc));
    assign last = (k_q == len_q - 1'b1);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        len_d   = len_q;
        vert_d  = vert_q;
        cells_d = cells_q;
        ships_d = ships_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        unique case (1'b1)
            (state_q == S_IDLE): begin
                if (bus.enable && clear_rel) begin
                    cells_d = '0;
                    ships_d = '0;
                    code_d  = E_NONE;
                end else if (bus.enable && place_rel) begin
                    if (quota_hit) begin
                        err_d  = 1'b1;
                        code_d = E_QUOTA;
                    end else if (bounds_bad) begin
                        err_d  = 1'b1;
                        code_d = E_BNDS;
                    end else begin
                        row_d   = bus.row;
                        col_d   = bus.col;
                        len_d   = bus.ship_len;
                        vert_d  = bus.vertical;
                        k_d     = '0;
                        state_d = S_CHECK;
                    end
                end
            end
            (state_q == S_CHECK): begin
                if (cells_q[idx]) begin
                    err_d   = 1'b1;
                    code_d  = E_OVLP;
                    k_d     = '0;
                    state_d = S_IDLE;
                end else if (last) begin
                    k_d     = '0;
                    state_d = S_WRITE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            (state_q == S_WRITE): begin
                cells_d[idx] = 1'b1;
                if (last) begin
                    ok_d    = 1'b1;
                    code_d  = E_NONE;
                    ships_d = ships_q + 3'd1;
                    k_d     = '0;
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: begin
                k_d     = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Board logic runs on the falling edge of the system clock.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            len_q   <= '0;
            vert_q  <= 1'b0;
            cells_q <= '0;
            ships_q <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= E_NONE;
            pprev_q <= 1'b0;
            cprev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            len_q   <= len_d;
            vert_q  <= vert_d;
            cells_q <= cells_d;
            ships_q <= ships_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
            pprev_q <= bus.place_btn;
            cprev_q <= bus.clear_btn;
        end
    end

    for (genvar i = 0; i < NC; i++) begin : g_board
        assign bus.board[2*i +: 2] = {1'b0, cells_q[i]};
    end

    assign bus.ships_placed = ships_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.place_ok     = ok_q;
    assign bus.place_err    = err_q;
    assign bus.err_code     = code_q;
    assign bus.finished     = (ships_q == bus.target_ships);
endmodule

// File: tb/tb_ship_placer.sv
// Bench for ship_placer: directed scenarios plus random stimulus,
// every cycle compared against a timeline model of placements.
module tb_ship_placer;
    localparam int N     = 5;
    localparam int LEN_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ship_placer_if #(.N(N), .LEN_W(LEN_W)) bus ();

    ship_placer #(.N(N), .MAX_SHIPS(5), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    bit m_cells [N][N];
    int m_ships;
    int m_code;
    bit m_ok;
    bit m_err;
    bit m_pp;
    bit m_cp;
    bit op_on;
    int op_age;
    int op_len;
    int op_r;
    int op_c;
    bit op_v;
    int op_ovl;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m_cells[r][c] = 1'b0;
        m_ships = 0;
        m_code  = 0;
        m_ok    = 1'b0;
        m_err   = 1'b0;
        m_pp    = 1'b0;
        m_cp    = 1'b0;
        op_on   = 1'b0;
        op_age  = 0;
        op_ovl  = -1;
    endfunction

    function automatic void cell_at(input int k, output int r, output int c);
        r = op_v ? op_r + k : op_r;
        c = op_v ? op_c : op_c + k;
    endfunction

    function automatic logic [2*N*N-1:0] m_board();
        logic [2*N*N-1:0] b;
        b = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b[2*(r*N+c)] = m_cells[r][c];
        return b;
    endfunction

    // Outcome of a placement is decided at its release edge; later edges
    // just play out its timeline (scan len cells, then write len cells).
    task automatic model_step();
        bit pr;
        bit cr;
        int rr;
        int cc;
        int s;
        int x;
        if (!rst) begin
            m_reset();
            return;
        end
        pr    = m_pp && !bus.place_btn;
        cr    = m_cp && !bus.clear_btn;
        m_pp  = bus.place_btn;
        m_cp  = bus.clear_btn;
        m_ok  = 1'b0;
        m_err = 1'b0;
        if (op_on) begin
            op_age++;
            if (op_ovl >= 0) begin
                if (op_age == op_ovl + 1) begin
                    m_err  = 1'b1;
                    m_code = 2;
                    op_on  = 1'b0;
                end
            end else begin
                if (op_age >= op_len + 1) begin
                    cell_at(op_age - op_len - 1, rr, cc);
                    m_cells[rr][cc] = 1'b1;
                end
                if (op_age == 2 * op_len) begin
                    m_ok   = 1'b1;
                    m_ships++;
                    m_code = 0;
                    op_on  = 1'b0;
                end
            end
        end else if (bus.enable) begin
            s = bus.vertical ? int'(bus.row) : int'(bus.col);
            x = bus.vertical ? int'(bus.col) : int'(bus.row);
            if (cr) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        m_cells[r][c] = 1'b0;
                m_ships = 0;
                m_code  = 0;
            end else if (pr) begin
                if (m_ships >= int'(bus.target_ships)) begin
                    m_err  = 1'b1;
                    m_code = 3;
                end else if (bus.ship_len == 0 || s + int'(bus.ship_len) > N || x >= N) begin
                    m_err  = 1'b1;
                    m_code = 1;
                end else begin
                    op_r   = int'(bus.row);
                    op_c   = int'(bus.col);
                    op_len = int'(bus.ship_len);
                    op_v   = bus.vertical;
                    op_on  = 1'b1;
                    op_age = 0;
                    op_ovl = -1;
                    for (int k = 0; k < op_len; k++) begin
                        cell_at(k, rr, cc);
                        if (m_cells[rr][cc] && op_ovl < 0) op_ovl = k;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("busy", 64'(bus.busy), 64'(op_on));
        chk("place_ok", 64'(bus.place_ok), 64'(m_ok));
        chk("place_err", 64'(bus.place_err), 64'(m_err));
        chk("err_code", 64'(bus.err_code), 64'(m_code));
        chk("ships", 64'(bus.ships_placed), 64'(m_ships));
        chk("finished", 64'(bus.finished), 64'(m_ships == int'(bus.target_ships)));
        chk("board", 64'(bus.board), 64'(m_board()));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        compare();
    endtask

    task automatic press_release();
        bus.place_btn = 1'b1;
        step();
        bus.place_btn = 1'b0;
        step();
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (bus.busy && cnt < 40) begin
            cnt++;
            step();
        end
    endtask

    task automatic setup(int r, int c, int l, bit v);
        bus.row      = r[2:0];
        bus.col      = c[2:0];
        bus.ship_len = l[LEN_W-1:0];
        bus.vertical = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.enable       = 1'b0;
        bus.row          = '0;
        bus.col          = '0;
        bus.ship_len     = '0;
        bus.vertical     = 1'b0;
        bus.target_ships = 3'd2;
        bus.place_btn    = 1'b0;
        bus.clear_btn    = 1'b0;
        m_reset();
        #1 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rst_board", 64'(bus.board), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_code", 64'(bus.err_code), 64'd0);

        bus.enable = 1'b1;
        setup(1, 0, 3, 1'b0);
        press_release();
        wait_idle(cnt);
        chk("s1_latency", 64'(cnt), 64'd6);
        chk("s1_ok", 64'(bus.place_ok), 64'd1);
        chk("s1_board", 64'(bus.board), 64'h5400);
        chk("s1_ships", 64'(bus.ships_placed), 64'd1);
        chk("s1_fin", 64'(bus.finished), 64'd0);

        setup(0, 1, 3, 1'b1);
        press_release();
        wait_idle(cnt);
        chk("ovl_lat", 64'(cnt), 64'd2);
        chk("ovl_err", 64'(bus.place_err), 64'd1);
        chk("ovl_code", 64'(bus.err_code), 64'd2);
        chk("ovl_board", 64'(bus.board), 64'h5400);
        chk("ovl_ships", 64'(bus.ships_placed), 64'd1);

        setup(3, 4, 3, 1'b1);
        press_release();
        chk("bnd_err", 64'(bus.place_err), 64'd1);
        chk("bnd_code", 64'(bus.err_code), 64'd1);
        chk("bnd_busy", 64'(bus.busy), 64'd0);
        setup(0, 0, 0, 1'b0);
        press_release();
        chk("len0_err", 64'(bus.place_err), 64'd1);
        chk("len0_code", 64'(bus.err_code), 64'd1);

        setup(4, 0, 2, 1'b0);
        press_release();
        wait_idle(cnt);
        chk("s2_lat", 64'(cnt), 64'd4);
        chk("s2_ok", 64'(bus.place_ok), 64'd1);
        chk("s2_fin", 64'(bus.finished), 64'd1);
        chk("s2_board", 64'(bus.board), 64'h500_0000_5400);

        setup(2, 2, 1, 1'b0);
        press_release();
        chk("quota_err", 64'(bus.place_err), 64'd1);
        chk("quota_code", 64'(bus.err_code), 64'd3);

        bus.place_btn = 1'b1;
        bus.clear_btn = 1'b1;
        step();
        bus.place_btn = 1'b0;
        bus.clear_btn = 1'b0;
        step();
        chk("clr_board", 64'(bus.board), 64'd0);
        chk("clr_ships", 64'(bus.ships_placed), 64'd0);
        chk("clr_ok", 64'(bus.place_ok), 64'd0);
        chk("clr_code", 64'(bus.err_code), 64'd0);

        setup(2, 0, 2, 1'b0);
        press_release();
        bus.place_btn = 1'b1;
        step();
        bus.place_btn = 1'b0;
        step();
        wait_idle(cnt);
        chk("drop_ok", 64'(bus.place_ok), 64'd1);
        step();
        step();
        chk("drop_busy", 64'(bus.busy), 64'd0);
        chk("drop_ships", 64'(bus.ships_placed), 64'd1);

        setup(3, 0, 4, 1'b0);
        press_release();
        repeat (5) step();
        chk("wr_partial", 64'(bus.board), 64'h4050_0000);
        rst = 1'b0;
        #1;
        chk("ar_busy", 64'(bus.busy), 64'd0);
        chk("ar_board", 64'(bus.board), 64'd0);
        chk("ar_ships", 64'(bus.ships_placed), 64'd0);
        chk("ar_code", 64'(bus.err_code), 64'd0);
        chk("ar_pulse", 64'({bus.place_ok, bus.place_err}), 64'd0);
        step();
        rst = 1'b1;
        step();

        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom % 600) != 0;
            bus.enable    = ($urandom % 8) != 0;
            bus.place_btn = ($urandom % 4) == 0;
            bus.clear_btn = ($urandom % 60) == 0;
            bus.row       = 3'($urandom_range(0, N - 1));
            bus.col       = 3'($urandom_range(0, N - 1));
            bus.ship_len  = 3'($urandom % 8);
            bus.vertical  = 1'($urandom % 2);
            if (($urandom % 200) == 0)
                bus.target_ships = 3'($urandom_range(1, 5));
            step();
        end
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
